// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode signals of the fetch stage
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with in-order queue and redirect squash
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [AW-1:0] head, tail;
  logic [31:0]   q_pc [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [CW:0]   credit;
  logic          redir, rsp, accept, push, pop;
  logic [31:0]   redir_pc;
  assign redir    = bus.redirect_valid;
  assign rsp      = bus.imem_rsp_valid;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
  // credit counts only registered state, so a same-cycle pop never frees a slot early
  assign credit             = {1'b0, outstanding} + {1'b0, count};
  assign bus.imem_req_valid = rst_n & ~redir & (credit < (CW+1)'(QDEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign accept             = bus.imem_req_valid & bus.imem_req_ready;
  assign push               = rsp & ~redir & (drop_cnt == '0);
  assign pop                = bus.dec_valid & bus.dec_ready & ~redir;
  assign bus.dec_valid      = count != '0;
  assign bus.dec_inst       = q_inst[head];
  assign bus.dec_pc         = q_pc[head];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (redir) begin
        fetch_pc <= redir_pc;
        resp_pc  <= redir_pc;
        drop_cnt <= outstanding - CW'(rsp);
        count    <= '0;
        tail     <= head;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          q_pc[tail]   <= resp_pc;
          q_inst[tail] <= bus.imem_rsp_data;
          tail         <= tail + AW'(1);
          resp_pc      <= resp_pc + 32'd4;
        end
        if (pop) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(rsp && outstanding == '0));
      assert (!(push && !pop && count == CW'(QDEPTH)));
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-configurable memory model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_unit_if bus ();
  fetch_unit_if bus2 ();
  fetch_unit u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus2));
  int checks = 0, passes = 0, cyc = 0, lat = 1;
  int accepts = 0, limit = 0, accepts2 = 0, limit2 = 0, start = 0;
  logic [31:0] pa[$], exp_req[$], exp_dec[$], exp_req2[$], exp_dec2[$];
  int pd[$];
  logic acc2;
  logic [31:0] a2, e1, e2;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic none(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask
  // memory: accepts up to 'limit' requests, answers in order after 'lat' cycles; reset with the DUT
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
      pa.push_back(bus.imem_req_addr);
      pd.push_back(cyc + lat);
      accepts++;
    end
    acc2 = rst_n && bus2.imem_req_valid && bus2.imem_req_ready;
    a2 = bus2.imem_req_addr;
    if (acc2) accepts2++;
    #2;
    if (!rst_n) begin
      pa.delete();
      pd.delete();
    end
    if (pd.size() != 0 && pd[0] <= cyc + 1) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = mem_word(pa.pop_front());
      void'(pd.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = '0;
    end
    bus.imem_req_ready = accepts < limit;
    bus2.imem_rsp_valid = acc2 && rst_n;
    bus2.imem_rsp_data = mem_word(a2);
    bus2.imem_req_ready = accepts2 < limit2;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (exp_req.size() == 0) none("req_addr", bus.imem_req_addr);
        else begin e1 = exp_req.pop_front(); chk("req_addr", bus.imem_req_addr, e1); end
      end
      if (bus.dec_valid && bus.dec_ready && !bus.redirect_valid) begin
        if (exp_dec.size() == 0) none("dec_pc", bus.dec_pc);
        else begin
          e1 = exp_dec.pop_front();
          chk("dec_pc", bus.dec_pc, e1);
          chk("dec_inst", bus.dec_inst, mem_word(e1));
        end
      end
      if (bus2.imem_req_valid && bus2.imem_req_ready) begin
        if (exp_req2.size() == 0) none("wrap_req_addr", bus2.imem_req_addr);
        else begin e2 = exp_req2.pop_front(); chk("wrap_req_addr", bus2.imem_req_addr, e2); end
      end
      if (bus2.dec_valid && bus2.dec_ready) begin
        if (exp_dec2.size() == 0) none("wrap_dec_pc", bus2.dec_pc);
        else begin
          e2 = exp_dec2.pop_front();
          chk("wrap_dec_pc", bus2.dec_pc, e2);
          chk("wrap_dec_inst", bus2.dec_inst, mem_word(e2));
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic redir(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    step(1);
    bus.redirect_valid = 1'b0;
  endtask
  task automatic push_pcs(input logic [31:0] base, input int n, input bit dec);
    for (int i = 0; i < n; i++) begin
      exp_req.push_back(base + 32'(4 * i));
      if (dec) exp_dec.push_back(base + 32'(4 * i));
    end
  endtask
  task automatic wait_grant();
    for (int i = 0; i < 50 && accepts < limit; i++) step(1);
    chk("grant_used", 32'(limit - accepts), 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && (exp_req.size() + exp_dec.size() + exp_req2.size() + exp_dec2.size()) != 0; i++) step(1);
    chk("drained", 32'(exp_req.size() + exp_dec.size() + exp_req2.size() + exp_dec2.size()), 0);
  endtask
  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.dec_ready = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = '0;
    bus2.dec_ready = 1'b1;
    step(1);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_dec_pc", bus.dec_pc, 0);
    chk("rst_dec_inst", bus.dec_inst, 0);
    step(1);
    rst_n = 1'b1;
    exp_req2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_dec2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    limit2 = 3;
    // streaming with 1-cycle memory: one accept per cycle
    push_pcs(32'h0, 6, 1);
    start = cyc;
    limit = accepts + 6;
    wait_grant();
    chk("stream_cycles", 32'(cyc - start), 6);
    drain();
    // decode stalled: credit stops at four requests
    redir(32'h0);
    bus.dec_ready = 1'b0;
    push_pcs(32'h0, 10, 1);
    start = accepts;
    limit = accepts + 10;
    step(10);
    chk("stall_accepts", 32'(accepts - start), 4);
    chk("stall_req_valid", bus.imem_req_valid, 0);
    chk("stall_dec_valid", bus.dec_valid, 1);
    chk("stall_head_pc", bus.dec_pc, 0);
    bus.dec_ready = 1'b1;
    drain();
    // 3-cycle memory, redirect with two requests in flight
    redir(32'h8);
    lat = 3;
    push_pcs(32'h8, 2, 0);
    push_pcs(32'h100, 3, 1);
    limit = accepts + 2;
    wait_grant();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    limit = accepts + 3;
    step(1);
    bus.redirect_valid = 1'b0;
    chk("redir_flush", bus.dec_valid, 0);
    drain();
    // redirect coinciding with a response and a pop
    lat = 1;
    redir(32'h200);
    bus.dec_ready = 1'b0;
    push_pcs(32'h200, 2, 0);
    push_pcs(32'h300, 2, 1);
    limit = accepts + 2;
    wait_grant();
    bus.dec_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    limit = accepts + 2;
    step(1);
    bus.redirect_valid = 1'b0;
    chk("coincide_flush", bus.dec_valid, 0);
    drain();
    // reset with two in flight and two queued
    lat = 3;
    redir(32'h400);
    bus.dec_ready = 1'b0;
    push_pcs(32'h400, 4, 0);
    start = accepts;
    limit = accepts + 5;
    step(5);
    chk("pre_rst_dec_valid", bus.dec_valid, 1);
    chk("pre_rst_accepts", 32'(accepts - start), 4);
    rst_n = 1'b0;
    limit = accepts;
    #1;
    chk("midrst_dec_valid", bus.dec_valid, 0);
    chk("midrst_req_valid", bus.imem_req_valid, 0);
    step(2);
    rst_n = 1'b1;
    chk("post_rst_req_addr", bus.imem_req_addr, 32'h0);
    push_pcs(32'h0, 2, 1);
    bus.dec_ready = 1'b1;
    limit = accepts + 2;
    drain();
    step(5);
    chk("idle_dec_valid", bus.dec_valid, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
